array_multiplier_dot: RTL and testbench
=======================================

# array_multiplier_dot

Parametrised multi-lane dot-product engine built from pipelined array multipliers. Each accepted beat multiplies NUM_LANES operand pairs and sums the products into one value. That value is either returned per beat or accumulated across a group of beats ended by `i_last`. It is the successor to the two-multiplier summing top: lane count, signedness, pipeline depth and accumulation are all configurable, and valid/last/overflow are tracked through the pipeline.

## Interface
- DATAWIDTH, 8, operand width per lane (≥2)
- NUM_LANES, 2, number of parallel multipliers (≥1)
- NUM_PIPELINE_STAGES, 1, register cuts inside each partial-product array (0..DATAWIDTH-1), applied identically to all lanes
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
- ACC_GUARD, 4, extra accumulator guard bits
- ACC_WIDTH (derived, not overridable), 2*DATAWIDTH + $clog2(NUM_LANES) + ACC_GUARD

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  beat qualifier; no backpressure, may be high every cycle
- i_last  in  1  closes the accumulation group; ignored when i_acc=0
- i_acc  in  1  1 = beat joins the accumulation group, 0 = standalone beat
- A  in  NUM_LANES*DATAWIDTH  lane k operand in bits [k*DATAWIDTH +: DATAWIDTH]
- B  in  NUM_LANES*DATAWIDTH  same packing as A
- o_valid  out  1  Z_final valid, one-cycle pulse per result
- o_last  out  1  result closes an accumulation group
- o_overflow  out  1  result exceeded the ACC_WIDTH range (see Operation)
- Z_final  out  ACC_WIDTH  result, modulo 2^ACC_WIDTH

## Operation
- Per beat: P_k = A_k × B_k, each 2*DATAWIDTH wide and sign- or zero-extended per SIGNED. S = ΣP_k, extended to ACC_WIDTH.
- i_valid, i_last and i_acc travel in a sideband shift register aligned to the product pipeline. Per-beat mode is honoured, so mixing modes back-to-back is legal.
- Accumulator FSM:
  - IDLE: an acc beat without last moves to ACCUM with acc = S. An acc beat with last emits S and stays in IDLE.
  - ACCUM: acc += S. An acc beat with last emits acc+S, then acc clears to 0 and the FSM returns to IDLE.
- Standalone beats (i_acc=0): emit S with o_last=0. The accumulator and FSM state are untouched, even when a group is open.
- Bubbles (i_valid=0): no state change. A group stays open indefinitely.
- Overflow detection:
  - Checked on each add: unsigned carry-out, or signed overflow per two's-complement rules.
  - Sticky per group; reported with the closing result, then cleared.
  - Standalone beats always report o_overflow=0. Their range cannot be exceeded.
- Wrap-around: Z_final keeps the low ACC_WIDTH bits. No saturation.
- When o_valid=0, Z_final, o_last and o_overflow hold their last values. Only o_valid is authoritative.

## Timing
- Latency L = NUM_PIPELINE_STAGES + 2 cycles, from the edge that samples i_valid=1 to o_valid=1. This is one multiplier output register plus one result register, in addition to the internal cuts.
- Throughput is one beat per cycle for any parameter set.
- Results appear in input order. In acc mode, only the closing beat produces an o_valid pulse.
- While rst is low, asynchronously: all outputs = 0, sideband valids = 0, accumulator = 0, FSM = IDLE.
- In-flight beats and any open group are discarded on reset. The first beat sampled on the first edge after rst rises is handled normally.
- A beat with i_acc=1 and i_last=1 in IDLE gives o_valid=1, o_last=1 after L cycles.

## Test plan
- Defaults except DATAWIDTH=4; L=3, ACC_WIDTH=13. One standalone beat A={3,15}, B={5,15} -> o_valid pulse 3 cycles later, Z_final=240, o_last=0, o_overflow=0.
- Eight standalone beats on consecutive cycles with random operands -> eight consecutive o_valid pulses starting at L. Each Z_final matches a reference model, in order.
- Acc group of three beats with lane sums 10, 20, 30, one idle cycle between beats 2 and 3, i_last on beat 3 -> exactly one o_valid pulse, 3 cycles after beat 3, Z_final=60, o_last=1.
- Nineteen acc beats of A={15,15}, B={15,15} (S=450), last on the 19th -> Z_final=358 (8550 mod 8192), o_overflow=1. The next one-beat group of S=1 gives Z_final=1, o_overflow=0.
- SIGNED=1: A={-8,7}, B={7,-8}, standalone -> Z_final=8080 (-112). Then a standalone beat interleaved inside an open acc group leaves the group total unchanged.
- Two acc beats (S=5 each), then rst low for 2 cycles mid-group -> outputs 0 during reset. After release, one acc beat S=5 with last -> Z_final=5 with no stale sum and no spurious o_valid.

Source files
------------

// File: rtl/array_multiplier_dot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : array_multiplier_dot
//  Purpose  : Multi-lane dot-product engine. Each accepted beat multiplies
//             NUM_LANES operand pairs in pipelined array multipliers and sums
//             the products. The sum is either returned per beat (i_acc=0) or
//             accumulated across a group of beats closed by i_last.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous, active-low reset
//             i_valid    - beat qualifier (no backpressure)
//             i_last     - closes an accumulation group (only with i_acc=1)
//             i_acc      - 1 = beat joins the group, 0 = standalone beat
//             A, B       - NUM_LANES packed operands, lane k at [k*DW +: DW]
//             o_valid    - one-cycle result strobe
//             o_last     - result closes an accumulation group
//             o_overflow - group result left the ACC_WIDTH range
//             Z_final    - result, modulo 2^ACC_WIDTH (held when o_valid=0)
//  Latency  : NUM_PIPELINE_STAGES + 2 cycles after the sampling edge
//  Revision : 1.0 - initial release
// ============================================================================
module array_multiplier_dot #(
    parameter  int DATAWIDTH           = 8,
    parameter  int NUM_LANES           = 2,
    parameter  int NUM_PIPELINE_STAGES = 1,
    parameter  int SIGNED              = 0,
    parameter  int ACC_GUARD           = 4,
    localparam int ACC_WIDTH           = 2*DATAWIDTH + $clog2(NUM_LANES) + ACC_GUARD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic                           i_acc,
    input  logic [NUM_LANES*DATAWIDTH-1:0] A,
    input  logic [NUM_LANES*DATAWIDTH-1:0] B,
    output logic                           o_valid,
    output logic                           o_last,
    output logic                           o_overflow,
    output logic [ACC_WIDTH-1:0]           Z_final
);

    localparam int PW      = 2*DATAWIDTH;            // product width
    localparam int SB_LEN  = NUM_PIPELINE_STAGES + 2; // input reg + cuts + product reg

    // ------------------------------------------------------------------------
    // Input capture: the sampling edge loads operands and sideband together.
    // ------------------------------------------------------------------------
    logic [NUM_LANES*DATAWIDTH-1:0] a_d, a_q, b_d, b_q;
    logic [SB_LEN-1:0] sb_valid_d, sb_valid_q;
    logic [SB_LEN-1:0] sb_last_d,  sb_last_q;
    logic [SB_LEN-1:0] sb_acc_d,   sb_acc_q;

    always_comb begin
        a_d        = A;
        b_d        = B;
        // Sideband shift register: index SB_LEN-1 lines up with the product regs
        sb_valid_d = {sb_valid_q[SB_LEN-2:0], i_valid};
        sb_last_d  = {sb_last_q[SB_LEN-2:0],  i_last};
        sb_acc_d   = {sb_acc_q[SB_LEN-2:0],   i_acc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sb_valid_q <= '0;
            sb_last_q  <= '0;
            sb_acc_q   <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            sb_valid_q <= sb_valid_d;
            sb_last_q  <= sb_last_d;
            sb_acc_q   <= sb_acc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane array multiplier. Row r adds (multiplicand << r) when bit r of
    // the multiplier is set. In signed mode the multiplicand is sign-extended
    // and the top row subtracts, which gives the exact two's-complement
    // product in PW bits. Register cuts are spread evenly between rows.
    // ------------------------------------------------------------------------
    logic [NUM_LANES*PW-1:0] lane_prod;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [PW-1:0]        psum   [0:DATAWIDTH];
        logic [PW-1:0]        mcand  [0:DATAWIDTH-1];
        logic [DATAWIDTH-1:0] mplier [0:DATAWIDTH-1];
        logic [DATAWIDTH-1:0] a_lane;
        logic [PW-1:0]        prod_q;

        assign a_lane    = a_q[k*DATAWIDTH +: DATAWIDTH];
        assign psum[0]   = '0;
        assign mcand[0]  = (SIGNED != 0) ? {{DATAWIDTH{a_lane[DATAWIDTH-1]}}, a_lane}
                                         : {{DATAWIDTH{1'b0}}, a_lane};
        assign mplier[0] = b_q[k*DATAWIDTH +: DATAWIDTH];

        for (genvar r = 0; r < DATAWIDTH; r++) begin : g_row
            localparam bit NEG_ROW = (SIGNED != 0) && (r == DATAWIDTH-1);
            logic [PW-1:0] pp;
            logic [PW-1:0] row_sum_d;

            always_comb begin
                pp = mplier[r][r] ? (mcand[r] << r) : '0;
                if (NEG_ROW) row_sum_d = psum[r] - pp;
                else         row_sum_d = psum[r] + pp;
            end

            if (r < DATAWIDTH-1) begin : g_link
                // Stage index of a row; a cut sits wherever it increments
                localparam int STG_HERE = (r     * (NUM_PIPELINE_STAGES+1)) / DATAWIDTH;
                localparam int STG_NEXT = ((r+1) * (NUM_PIPELINE_STAGES+1)) / DATAWIDTH;
                if (STG_NEXT != STG_HERE) begin : g_cut
                    logic [PW-1:0]        psum_q;
                    logic [PW-1:0]        mcand_q;
                    logic [DATAWIDTH-1:0] mplier_q;
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            psum_q   <= '0;
                            mcand_q  <= '0;
                            mplier_q <= '0;
                        end else begin
                            psum_q   <= row_sum_d;
                            mcand_q  <= mcand[r];
                            mplier_q <= mplier[r];
                        end
                    end
                    assign psum[r+1]   = psum_q;
                    assign mcand[r+1]  = mcand_q;
                    assign mplier[r+1] = mplier_q;
                end else begin : g_wire
                    assign psum[r+1]   = row_sum_d;
                    assign mcand[r+1]  = mcand[r];
                    assign mplier[r+1] = mplier[r];
                end
            end else begin : g_tail
                assign psum[DATAWIDTH] = row_sum_d;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) prod_q <= '0;
            else      prod_q <= psum[DATAWIDTH];
        end

        assign lane_prod[k*PW +: PW] = prod_q;
    end

    // ------------------------------------------------------------------------
    // Lane reduction: extend each product to ACC_WIDTH and sum. The guard of
    // $clog2(NUM_LANES) bits makes this sum exact.
    // ------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] beat_sum;
    logic [PW-1:0]        p_k;
    logic [ACC_WIDTH-1:0] p_ext;

    always_comb begin
        beat_sum = '0;
        p_k      = '0;
        p_ext    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            p_k = lane_prod[k*PW +: PW];
            if (SIGNED != 0) p_ext = ACC_WIDTH'($signed(p_k));
            else             p_ext = ACC_WIDTH'(p_k);
            beat_sum = beat_sum + p_ext;
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator FSM and result register
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t               state_d, state_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                 grp_ovf_d, grp_ovf_q;
    logic [ACC_WIDTH-1:0] z_d, z_q;
    logic                 valid_d, valid_q;
    logic                 last_d, last_q;
    logic                 ovf_d, ovf_q;

    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   add_ext;
    logic                 add_ovf;
    logic                 grp_ovf_now;
    logic                 t_valid, t_last, t_acc;

    assign t_valid = sb_valid_q[SB_LEN-1];
    assign t_last  = sb_last_q[SB_LEN-1];
    assign t_acc   = sb_acc_q[SB_LEN-1];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        grp_ovf_d = grp_ovf_q;
        z_d       = z_q;
        valid_d   = 1'b0;
        last_d    = last_q;
        ovf_d     = ovf_q;

        // The first beat of a group adds to zero, so it can never overflow
        base    = (state_q == ST_ACCUM) ? acc_q : '0;
        add_ext = {1'b0, base} + {1'b0, beat_sum};
        if (SIGNED != 0)
            add_ovf = (base[ACC_WIDTH-1] == beat_sum[ACC_WIDTH-1]) &&
                      (add_ext[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        else
            add_ovf = add_ext[ACC_WIDTH];
        grp_ovf_now = grp_ovf_q | add_ovf;

        if (t_valid) begin
            if (!t_acc) begin
                // Standalone beat: accumulator and state are left alone
                valid_d = 1'b1;
                z_d     = beat_sum;
                last_d  = 1'b0;
                ovf_d   = 1'b0;
            end else if (t_last) begin
                valid_d   = 1'b1;
                z_d       = add_ext[ACC_WIDTH-1:0];
                last_d    = 1'b1;
                ovf_d     = grp_ovf_now;
                acc_d     = '0;
                grp_ovf_d = 1'b0;
                state_d   = ST_IDLE;
            end else begin
                acc_d     = add_ext[ACC_WIDTH-1:0];
                grp_ovf_d = grp_ovf_now;
                state_d   = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            grp_ovf_q <= 1'b0;
            z_q       <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            grp_ovf_q <= grp_ovf_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;
    assign Z_final    = z_q;

endmodule
`default_nettype wire

// File: tb/tb_array_multiplier_dot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_array_multiplier_dot
//  Purpose  : Bench for array_multiplier_dot. One unsigned and one signed
//             instance (DATAWIDTH=4, two lanes, one cut: L=3, ACC_WIDTH=13)
//             are driven with directed and random beats; an integer model
//             predicts every result and the cycle it must appear on.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_array_multiplier_dot;

    localparam int DW  = 4;
    localparam int NL  = 2;
    localparam int NPS = 1;
    localparam int L   = NPS + 2;
    localparam int AW  = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance 0: unsigned, instance 1: signed
    logic          u_valid = 0, u_last = 0, u_acc = 0;
    logic [NL*DW-1:0] u_a = '0, u_b = '0;
    logic          u_ov, u_ol, u_oo;
    logic [AW-1:0] u_z;
    logic          s_valid = 0, s_last = 0, s_acc = 0;
    logic [NL*DW-1:0] s_a = '0, s_b = '0;
    logic          s_ov, s_ol, s_oo;
    logic [AW-1:0] s_z;

    array_multiplier_dot #(.DATAWIDTH(DW), .NUM_LANES(NL), .NUM_PIPELINE_STAGES(NPS),
                           .SIGNED(0), .ACC_GUARD(4)) u_dut (
        .clk(clk), .rst(rst), .i_valid(u_valid), .i_last(u_last), .i_acc(u_acc),
        .A(u_a), .B(u_b), .o_valid(u_ov), .o_last(u_ol), .o_overflow(u_oo), .Z_final(u_z));

    array_multiplier_dot #(.DATAWIDTH(DW), .NUM_LANES(NL), .NUM_PIPELINE_STAGES(NPS),
                           .SIGNED(1), .ACC_GUARD(4)) s_dut (
        .clk(clk), .rst(rst), .i_valid(s_valid), .i_last(s_last), .i_acc(s_acc),
        .A(s_a), .B(s_b), .o_valid(s_ov), .o_last(s_ol), .o_overflow(s_oo), .Z_final(s_z));

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int     due;
        longint z;
        int     last;
        int     ovf;
    } exp_t;

    exp_t   qu[$];
    exp_t   qs[$];
    bit     g_open [2];
    longint g_acc  [2];
    bit     g_ovf  [2];

    function automatic longint wrapu(input longint v);
        return ((v % 8192) + 8192) % 8192;
    endfunction

    function automatic longint lane_val(input int id, input logic [DW-1:0] x);
        if (id == 1 && x >= 8) return longint'(x) - 16;
        return longint'(x);
    endfunction

    function automatic void push(input int id, input exp_t e);
        if (id == 0) qu.push_back(e);
        else         qs.push_back(e);
    endfunction

    function automatic void model_reset();
        qu.delete();
        qs.delete();
        for (int i = 0; i < 2; i++) begin
            g_open[i] = 0;
            g_acc[i]  = 0;
            g_ovf[i]  = 0;
        end
    endfunction

    function automatic void model(input int id, input logic [7:0] a, input logic [7:0] b,
                                  input bit acc, input bit last, input int due);
        longint s;
        longint n;
        bit     o;
        exp_t   e;
        s = lane_val(id, a[3:0]) * lane_val(id, b[3:0])
          + lane_val(id, a[7:4]) * lane_val(id, b[7:4]);
        e.due = due;
        if (!acc) begin
            e.z = wrapu(s); e.last = 0; e.ovf = 0;
            push(id, e);
        end else begin
            n = (g_open[id] ? g_acc[id] : 0) + s;
            o = g_open[id] ? g_ovf[id] : 1'b0;
            if (id == 0 ? (n > 8191) : (n > 4095 || n < -4096)) o = 1'b1;
            n = wrapu(n);
            if (id == 1 && n >= 4096) n = n - 8192;
            if (last) begin
                e.z = wrapu(n); e.last = 1; e.ovf = int'(o);
                push(id, e);
                g_open[id] = 0; g_acc[id] = 0; g_ovf[id] = 0;
            end else begin
                g_open[id] = 1; g_acc[id] = n; g_ovf[id] = o;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Output monitor (negedge sampling)
    // ------------------------------------------------------------------
    function automatic int qsize(input int id);
        return (id == 0) ? qu.size() : qs.size();
    endfunction

    function automatic exp_t qpop(input int id);
        if (id == 0) return qu.pop_front();
        return qs.pop_front();
    endfunction

    function automatic int qdue(input int id);
        return (id == 0) ? qu[0].due : qs[0].due;
    endfunction

    task automatic mon(input int id, input logic v, input logic [AW-1:0] z,
                       input logic l, input logic o);
        exp_t  e;
        string p;
        p = (id == 0) ? "u" : "s";
        if (!rst) begin
            chk({p, "_rst_valid"}, v, 0);
            chk({p, "_rst_z"}, z, 0);
            chk({p, "_rst_last"}, l, 0);
            chk({p, "_rst_ovf"}, o, 0);
            return;
        end
        while (qsize(id) > 0 && qdue(id) < cyc) begin
            e = qpop(id);
            chk({p, "_missing_pulse_cycle"}, cyc, e.due);
        end
        if (v) begin
            if (qsize(id) == 0) begin
                chk({p, "_spurious_valid"}, v, 0);
            end else begin
                e = qpop(id);
                chk({p, "_latency"}, cyc, e.due);
                chk({p, "_z"}, z, e.z);
                chk({p, "_last"}, l, e.last);
                chk({p, "_ovf"}, o, e.ovf);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, u_ov, u_z, u_ol, u_oo);
        mon(1, s_ov, s_z, s_ol, s_oo);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int id, input logic [7:0] a, input logic [7:0] b,
                        input bit acc, input bit last);
        if (id == 0) begin
            u_valid = 1; u_a = a; u_b = b; u_acc = acc; u_last = last;
        end else begin
            s_valid = 1; s_a = a; s_b = b; s_acc = acc; s_last = last;
        end
        model(id, a, b, acc, last, cyc + 1 + L);
        @(posedge clk);
        #1;
        u_valid = 0;
        s_valid = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        model_reset();
        idle(n);
        rst = 1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        idle(3);
        rst = 1;
        idle(2);

        // Directed standalone beat: 3*5 + 15*15 = 240
        beat(0, 8'hF3, 8'hF5, 0, 0);
        idle(L + 2);
        chk("u_hold_z_240", u_z, 240);
        chk("u_hold_last_0", u_ol, 0);

        // Eight back-to-back random standalone beats
        for (int i = 0; i < 8; i++)
            beat(0, 8'($urandom), 8'($urandom), 0, 0);
        idle(L + 1);

        // Group 10 + 20 + (bubble) + 30
        beat(0, 8'h12, 8'h43, 1, 0);
        beat(0, 8'h24, 8'h43, 1, 0);
        idle(1);
        beat(0, 8'h55, 8'h33, 1, 1);
        idle(L + 2);
        chk("u_grp_z_60", u_z, 60);
        chk("u_grp_last_1", u_ol, 1);

        // Nineteen beats of 450 overflow the 13-bit accumulator
        for (int i = 0; i < 19; i++)
            beat(0, 8'hFF, 8'hFF, 1, (i == 18));
        idle(L + 2);
        chk("u_wrap_z_358", u_z, 358);
        chk("u_wrap_ovf_1", u_oo, 1);
        beat(0, 8'h01, 8'h01, 1, 1);
        idle(L + 2);
        chk("u_next_z_1", u_z, 1);
        chk("u_next_ovf_0", u_oo, 0);

        // Signed: -8*7 + 7*-8 = -112 -> 8080
        beat(1, 8'h78, 8'h87, 0, 0);
        idle(L + 2);
        chk("s_z_8080", s_z, 8080);

        // Signed group with a standalone beat interleaved
        beat(1, 8'h3D, 8'h52, 1, 0);
        beat(1, 8'h9F, 8'hE7, 0, 0);
        beat(1, 8'hC4, 8'hB6, 1, 1);
        idle(L + 1);

        // Random mixed traffic on both instances
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0)
                idle(1);
            else
                beat(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                     bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        beat(0, 8'($urandom), 8'($urandom), 1, 1);
        beat(1, 8'($urandom), 8'($urandom), 1, 1);
        idle(L + 1);

        // Reset in the middle of an open group with beats in flight
        beat(0, 8'h11, 8'h32, 1, 0);
        beat(0, 8'h11, 8'h32, 1, 0);
        do_reset(2);
        beat(0, 8'h11, 8'h32, 1, 1);
        idle(L + 2);
        chk("u_post_rst_z_5", u_z, 5);
        chk("u_post_rst_last", u_ol, 1);

        idle(4);
        chk("u_outstanding", qu.size(), 0);
        chk("s_outstanding", qs.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
